sopc_mem_arbiter: RTL and testbench
===================================

# sopc_mem_arbiter

Parametrised two-master memory arbiter for the next-generation minimal SoC: the instruction-fetch port and the data port of the RISC-V core share one unified memory through it, instead of the core driving a dedicated instruction ROM directly. It sits between the core's fetch/load-store interfaces and a single memory macro. It adds configurable wait states, a request/acknowledge handshake, byte-lane writes and a selectable fixed-priority or round-robin grant policy.

## Interface

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; multiple of 8
- WAIT_CYCLES, 1, memory access wait states, legal 0..15
- RR_MODE, 0, 0 = data port always wins ties; 1 = round-robin on ties

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- m0_req  in  1  instruction-fetch request, held until m0_ack
- m0_addr  in  ADDR_W  fetch address, stable while m0_req
- m0_rdata  out  DATA_W  fetched word, valid in m0_ack cycle
- m0_ack  out  1  one-cycle completion pulse
- m1_req  in  1  data request, held until m1_ack
- m1_we  in  1  1 = write, 0 = read
- m1_addr  in  ADDR_W  data address
- m1_wdata  in  DATA_W  write data
- m1_sel  in  DATA_W/8  byte-lane enables (writes only)
- m1_rdata  out  DATA_W  read data, valid in m1_ack cycle
- m1_ack  out  1  one-cycle completion pulse
- s_ce  out  1  memory chip enable
- s_we  out  1  memory write strobe
- s_addr  out  ADDR_W  memory address
- s_wdata  out  DATA_W  memory write data
- s_sel  out  DATA_W/8  memory byte enables
- s_rdata  in  DATA_W  memory read data, combinational from s_addr

## Operation

- FSM states: IDLE, BUSY, DONE.
- IDLE: no request -> stay. Any request -> choose winner, latch its addr/we/wdata/sel and grant id, load cnt = WAIT_CYCLES, go BUSY.
- Tie (both req in IDLE): RR_MODE=0 -> m1; RR_MODE=1 -> master not equal to last_grant. last_grant updates on every grant.
- BUSY: s_ce=1, s_addr/s_wdata/s_sel from latches. cnt decrements each cycle. On the cnt==0 cycle: s_we = latched we (write strobe for exactly one cycle); s_rdata captured into the winner's rdata register; go DONE.
- DONE: winner's ack = 1 for one cycle; s_ce=0; no new grant evaluated; go IDLE.
- m0 is read-only: s_we never asserts on m0 grants; s_sel = all ones for m0.
- Loser's request stays pending and is granted in the next IDLE.
- rdata registers hold last captured value between transfers; non-winner's rdata unchanged.
- Request dropped during BUSY (protocol violation): transfer completes, ack still issued.

## Timing

- Reset (rst=0, asynchronous): state IDLE, cnt=0, last_grant=m0, all outputs 0 (s_ce, s_we, acks, rdata, s_addr, s_wdata, s_sel). Reset mid-transfer aborts: no ack, no write, s_ce low immediately.
- Latency: req sampled at edge k in IDLE -> BUSY for WAIT_CYCLES+1 cycles -> ack high in cycle k+WAIT_CYCLES+2.
- Throughput: one transfer per WAIT_CYCLES+3 cycles when back-to-back (IDLE, BUSY×(W+1), DONE).
- WAIT_CYCLES=0: BUSY lasts exactly one cycle; ack two cycles after the request edge.
- All outputs registered or decoded from registered state only; no combinational path from m*_req to s_*.

## Structure

- Package sopc_pkg: state encoding (IDLE/BUSY/DONE), master ids (MID_INST=0, MID_DATA=1), WAIT counter width (4 bits).
- One sub-module natural: sopc_grant (tie-break logic plus last_grant register, parametrised by RR_MODE).
- Top-level SoC instantiates core, sopc_mem_arbiter and one RAM.

## Test plan

- Reset: hold rst=0 with m0_req=1 -> all outputs 0; release -> m0_ack exactly at cycle WAIT_CYCLES+2 after first sampling edge.
- Single read, WAIT_CYCLES=2: m0_addr=0x100, memory holds 0x00000013 -> s_ce high 3 cycles, m0_ack one pulse at edge+4, m0_rdata=0x00000013.
- Byte write: m1_we=1, addr 0x200, wdata 0xAABBCCDD, sel 4'b0010 -> s_we one cycle with s_sel=0010; readback of 0x200 shows only byte 1 = 0xCC changed.
- Tie, RR_MODE=0: both req held continuously -> grant order m1, m1, ... until m1 drops, then m0.
- Tie, RR_MODE=1: both req held for four transfers -> grants alternate m1, m0, m1, m0 (last_grant reset = m0).
- Reset during BUSY of a write: rst low for one cycle mid-wait -> no s_we pulse, no ack, memory at target address unchanged, FSM back in IDLE.

Source files
------------

// File: rtl/sopc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sopc_pkg
// Purpose  : Shared definitions for the two-master memory arbiter: FSM state
//            encoding, master identifiers and the wait-state counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sopc_pkg;

    // Arbiter transfer phases
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Master identifiers, also used as the grant id
    localparam logic MID_INST = 1'b0;
    localparam logic MID_DATA = 1'b1;

    // Wait-state counter width; WAIT_CYCLES is limited to 0..15
    localparam int CNT_W = 4;

endpackage : sopc_pkg
`default_nettype wire

// File: rtl/sopc_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sopc_mem_arbiter_if
// Purpose  : Bundle of the instruction-fetch port (m0), the data port (m1)
//            and the single memory port (s_*) around the arbiter.
// Ports    : modport slave  - arbiter view (takes requests, drives memory)
//            modport master - environment view (cores and memory macro)
// Revision : 1.0 - initial release
// ============================================================================
interface sopc_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch port
    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_ack;

    // Data port
    logic                m1_req;
    logic                m1_we;
    logic [ADDR_W-1:0]   m1_addr;
    logic [DATA_W-1:0]   m1_wdata;
    logic [DATA_W/8-1:0] m1_sel;
    logic [DATA_W-1:0]   m1_rdata;
    logic                m1_ack;

    // Memory port
    logic                s_ce;
    logic                s_we;
    logic [ADDR_W-1:0]   s_addr;
    logic [DATA_W-1:0]   s_wdata;
    logic [DATA_W/8-1:0] s_sel;
    logic [DATA_W-1:0]   s_rdata;

    modport slave (
        input  m0_req, m0_addr,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_sel,
        input  s_rdata,
        output m0_rdata, m0_ack,
        output m1_rdata, m1_ack,
        output s_ce, s_we, s_addr, s_wdata, s_sel
    );

    modport master (
        output m0_req, m0_addr,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_sel,
        output s_rdata,
        input  m0_rdata, m0_ack,
        input  m1_rdata, m1_ack,
        input  s_ce, s_we, s_addr, s_wdata, s_sel
    );

endinterface : sopc_mem_arbiter_if
`default_nettype wire

// File: rtl/sopc_grant.sv
`default_nettype none
// ============================================================================
// Module   : sopc_grant
// Purpose  : Picks the winning master when a grant is taken and remembers the
//            last granted master for round-robin tie breaking.
// Ports    : clk, rst (async active-low)
//            m0_req, m1_req - pending requests
//            grant_en       - a grant is being taken this cycle
//            winner         - master id that wins (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module sopc_grant
    import sopc_pkg::*;
#(
    parameter int RR_MODE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic m0_req,
    input  logic m1_req,
    input  logic grant_en,
    output logic winner
);

    logic r_last_grant;
    logic w_tie_pick;

    // Fixed priority always hands ties to the data port; round-robin hands
    // them to whichever master did not get the previous grant.
    assign w_tie_pick = (RR_MODE != 0) ? ~r_last_grant : MID_DATA;

    always_comb begin
        winner = MID_INST;
        if (m0_req && m1_req) begin
            winner = w_tie_pick;
        end else if (m1_req) begin
            winner = MID_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= MID_INST;
        end else if (grant_en) begin
            r_last_grant <= winner;
        end
    end

endmodule : sopc_grant
`default_nettype wire

// File: rtl/sopc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sopc_mem_arbiter
// Purpose  : Two-master arbiter sharing one memory macro between the core's
//            instruction-fetch port (read-only) and its data port, with
//            configurable wait states and a req/ack handshake.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-low reset
//            bus  - sopc_mem_arbiter_if.slave (m0, m1 and memory port)
// Revision : 1.0 - initial release
// ============================================================================
module sopc_mem_arbiter
    import sopc_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1,
    parameter int RR_MODE     = 0
) (
    input  logic                clk,
    input  logic                rst,
    sopc_mem_arbiter_if.slave   bus
);

    localparam int               SEL_W    = DATA_W / 8;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_gnt;
    logic                r_we_lat;
    logic                r_s_ce;
    logic                r_s_we;
    logic [ADDR_W-1:0]   r_s_addr;
    logic [DATA_W-1:0]   r_s_wdata;
    logic [SEL_W-1:0]    r_s_sel;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic [DATA_W-1:0]   r_m1_rdata;
    logic                r_m0_ack;
    logic                r_m1_ack;

    logic                w_any_req;
    logic                w_grant_en;
    logic                w_winner;

    assign w_any_req  = bus.m0_req | bus.m1_req;
    assign w_grant_en = (r_state == IDLE) && w_any_req;

    sopc_grant #(
        .RR_MODE (RR_MODE)
    ) u_grant (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (bus.m0_req),
        .m1_req   (bus.m1_req),
        .grant_en (w_grant_en),
        .winner   (w_winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_gnt      <= MID_INST;
            r_we_lat   <= 1'b0;
            r_s_ce     <= 1'b0;
            r_s_we     <= 1'b0;
            r_s_addr   <= '0;
            r_s_wdata  <= '0;
            r_s_sel    <= '0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
        end else begin
            // Strobes default low so each one lasts a single cycle
            r_s_we   <= 1'b0;
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state <= BUSY;
                        r_cnt   <= CNT_LOAD;
                        r_gnt   <= w_winner;
                        r_s_ce  <= 1'b1;
                        if (w_winner == MID_DATA) begin
                            r_s_addr  <= bus.m1_addr;
                            r_s_wdata <= bus.m1_wdata;
                            r_s_sel   <= bus.m1_sel;
                            r_we_lat  <= bus.m1_we;
                            // With no wait states the first BUSY cycle is
                            // already the strobe cycle.
                            r_s_we    <= bus.m1_we && (WAIT_CYCLES == 0);
                        end else begin
                            // Fetch port is read-only: full word, no strobe
                            r_s_addr  <= bus.m0_addr;
                            r_s_wdata <= '0;
                            r_s_sel   <= '1;
                            r_we_lat  <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                        r_s_ce  <= 1'b0;
                        if (r_gnt == MID_DATA) begin
                            r_m1_rdata <= bus.s_rdata;
                            r_m1_ack   <= 1'b1;
                        end else begin
                            r_m0_rdata <= bus.s_rdata;
                            r_m0_ack   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        // Raise the strobe for the upcoming cnt==0 cycle
                        if (r_cnt == CNT_W'(1)) begin
                            r_s_we <= r_we_lat;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.s_ce     = r_s_ce;
    assign bus.s_we     = r_s_we;
    assign bus.s_addr   = r_s_addr;
    assign bus.s_wdata  = r_s_wdata;
    assign bus.s_sel    = r_s_sel;
    assign bus.m0_rdata = r_m0_rdata;
    assign bus.m0_ack   = r_m0_ack;
    assign bus.m1_rdata = r_m1_rdata;
    assign bus.m1_ack   = r_m1_ack;

endmodule : sopc_mem_arbiter
`default_nettype wire

// File: tb/tb_sopc_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sopc_mem_arbiter
// Purpose  : Self-checking bench. dut_a: WAIT_CYCLES=2, fixed priority, backed
//            by a byte-lane RAM. dut_b: WAIT_CYCLES=0, round-robin, backed by
//            an address-derived read pattern.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sopc_mem_arbiter;
    import sopc_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WA = 2;
    localparam int WB = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sopc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    sopc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    sopc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WA), .RR_MODE(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    sopc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WB), .RR_MODE(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // RAM behind dut_a: combinational read, byte-lane write on the clock edge
    logic [31:0] mem_a [256];
    assign bus_a.s_rdata = mem_a[bus_a.s_addr[9:2]];
    always @(posedge clk) begin
        if (bus_a.s_ce && bus_a.s_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_a.s_sel[b]) mem_a[bus_a.s_addr[9:2]][8*b +: 8] <= bus_a.s_wdata[8*b +: 8];
            end
        end
    end

    function automatic logic [31:0] pat_b(input logic [31:0] addr);
        return {addr[15:0], 16'hB00B};
    endfunction
    assign bus_b.s_rdata = pat_b(bus_b.s_addr);

    typedef struct packed {
        logic        mid;
        logic [31:0] rdata;
    } sb_t;

    sb_t sb_a[$];
    sb_t sb_b[$];

    int tests = 0;
    int fails = 0;
    int ce_a_cnt = 0;
    int we_a_cnt = 0;
    int we_b_cnt = 0;
    logic [3:0]  we_a_sel  = '0;
    logic [31:0] we_a_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Ack monitors: every ack pops the oldest expected transfer
    always @(negedge clk) begin : mon_a
        sb_t e;
        if (rst) begin
            if (bus_a.s_ce) ce_a_cnt++;
            if (bus_a.s_we) begin
                we_a_cnt++;
                we_a_sel  = bus_a.s_sel;
                we_a_addr = bus_a.s_addr;
            end
            if (bus_a.m0_ack || bus_a.m1_ack) begin
                chk("a_ack_both", {31'b0, bus_a.m0_ack & bus_a.m1_ack}, 32'd0);
                chk("a_sb_pending", {31'b0, sb_a.size() != 0}, 32'd1);
                if (sb_a.size() != 0) begin
                    e = sb_a.pop_front();
                    chk("a_ack_master", {31'b0, bus_a.m1_ack}, {31'b0, e.mid});
                    chk("a_rdata", bus_a.m1_ack ? bus_a.m1_rdata : bus_a.m0_rdata, e.rdata);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        sb_t e;
        if (rst) begin
            if (bus_b.s_we) we_b_cnt++;
            if (bus_b.m0_ack || bus_b.m1_ack) begin
                chk("b_ack_both", {31'b0, bus_b.m0_ack & bus_b.m1_ack}, 32'd0);
                chk("b_sb_pending", {31'b0, sb_b.size() != 0}, 32'd1);
                if (sb_b.size() != 0) begin
                    e = sb_b.pop_front();
                    chk("b_ack_master", {31'b0, bus_b.m1_ack}, {31'b0, e.mid});
                    chk("b_rdata", bus_b.m1_ack ? bus_b.m1_rdata : bus_b.m0_rdata, e.rdata);
                end
            end
        end
    end

    // Each transfer task starts with the DUT idle and leaves it idle again
    task automatic a_m0_read(input logic [31:0] addr, input logic [31:0] exp, output int lat);
        sb_a.push_back('{mid: MID_INST, rdata: exp});
        bus_a.m0_addr = addr;
        bus_a.m0_req  = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus_a.m0_ack && lat < 40);
        bus_a.m0_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic a_m1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] sel, input logic [31:0] exp, output int lat);
        sb_a.push_back('{mid: MID_DATA, rdata: exp});
        bus_a.m1_we    = we;
        bus_a.m1_addr  = addr;
        bus_a.m1_wdata = wdata;
        bus_a.m1_sel   = sel;
        bus_a.m1_req   = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus_a.m1_ack && lat < 40);
        bus_a.m1_req = 1'b0;
        bus_a.m1_we  = 1'b0;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        int we0;
        int n0;
        int n1;
        int cyc;

        bus_a.m0_req = 1'b0; bus_a.m0_addr = '0;
        bus_a.m1_req = 1'b0; bus_a.m1_we = 1'b0; bus_a.m1_addr = '0;
        bus_a.m1_wdata = '0; bus_a.m1_sel = '0;
        bus_b.m0_req = 1'b0; bus_b.m0_addr = '0;
        bus_b.m1_req = 1'b0; bus_b.m1_we = 1'b0; bus_b.m1_addr = '0;
        bus_b.m1_wdata = '0; bus_b.m1_sel = '0;
        for (int i = 0; i < 256; i++) mem_a[i] = 32'hA500_0000 | i;
        mem_a[64]  = 32'h0000_0013;
        mem_a[128] = 32'h1122_3344;
        mem_a[192] = 32'h5A5A_0300;

        // ---- Reset held with a pending fetch: everything stays at zero ----
        rst = 1'b0;
        bus_a.m0_addr = 32'h100;
        bus_a.m0_req  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_s_ce",     {31'b0, bus_a.s_ce}, 32'd0);
        chk("rst_s_we",     {31'b0, bus_a.s_we}, 32'd0);
        chk("rst_m0_ack",   {31'b0, bus_a.m0_ack}, 32'd0);
        chk("rst_m1_ack",   {31'b0, bus_a.m1_ack}, 32'd0);
        chk("rst_m0_rdata", bus_a.m0_rdata, 32'd0);
        chk("rst_m1_rdata", bus_a.m1_rdata, 32'd0);
        chk("rst_s_addr",   bus_a.s_addr, 32'd0);
        chk("rst_s_wdata",  bus_a.s_wdata, 32'd0);
        chk("rst_s_sel",    {28'b0, bus_a.s_sel}, 32'd0);
        chk("rst_b_s_ce",   {31'b0, bus_b.s_ce}, 32'd0);

        // ---- Release: first edge samples the request ----
        sb_a.push_back('{mid: MID_INST, rdata: 32'h0000_0013});
        rst = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus_a.m0_ack && lat < 40);
        bus_a.m0_req = 1'b0;
        chk("rst_release_latency", lat, WA + 2);
        chk("rst_release_ce_cycles", ce_a_cnt, WA + 1);
        @(negedge clk);

        // ---- Single fetch read ----
        ce_a_cnt = 0;
        a_m0_read(32'h100, 32'h0000_0013, lat);
        chk("read_latency", lat, WA + 2);
        chk("read_ce_cycles", ce_a_cnt, WA + 1);
        chk("read_no_we", we_a_cnt, 0);

        // ---- Byte-lane write, then readback ----
        we0 = we_a_cnt;
        a_m1(1'b1, 32'h200, 32'hAABB_CCDD, 4'b0010, 32'h1122_3344, lat);
        chk("wr_latency", lat, WA + 2);
        chk("wr_strobe_cycles", we_a_cnt - we0, 1);
        chk("wr_strobe_sel", {28'b0, we_a_sel}, 32'h2);
        chk("wr_strobe_addr", we_a_addr, 32'h200);
        a_m1(1'b0, 32'h200, 32'h0, 4'b0000, 32'h1122_CC44, lat);
        chk("rd_back_latency", lat, WA + 2);
        chk("m0_rdata_kept", bus_a.m0_rdata, 32'h0000_0013);

        // ---- Tie, fixed priority: data port keeps winning until it drops ----
        sb_a.push_back('{mid: MID_DATA, rdata: mem_a[16]});
        sb_a.push_back('{mid: MID_DATA, rdata: mem_a[16]});
        sb_a.push_back('{mid: MID_DATA, rdata: mem_a[16]});
        sb_a.push_back('{mid: MID_INST, rdata: mem_a[32]});
        bus_a.m1_we = 1'b0; bus_a.m1_addr = 32'h40; bus_a.m1_sel = 4'hF;
        bus_a.m0_addr = 32'h80;
        bus_a.m0_req = 1'b1;
        bus_a.m1_req = 1'b1;
        n0 = 0; n1 = 0; cyc = 0;
        while (n0 == 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus_a.m1_ack) begin
                n1++;
                if (n1 == 3) bus_a.m1_req = 1'b0;
            end
            if (bus_a.m0_ack) begin
                n0++;
                bus_a.m0_req = 1'b0;
            end
        end
        bus_a.m0_req = 1'b0;
        bus_a.m1_req = 1'b0;
        chk("tieA_m0_done", n0, 1);
        chk("tieA_m1_count", n1, 3);
        chk("tieA_throughput", cyc, (WA + 2) + 3 * (WA + 3));
        @(negedge clk);

        // ---- Reset in the middle of a write's wait states ----
        we0 = we_a_cnt;
        bus_a.m1_we = 1'b1; bus_a.m1_addr = 32'h300;
        bus_a.m1_wdata = 32'hFFFF_FFFF; bus_a.m1_sel = 4'hF;
        bus_a.m1_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_ce_before", {31'b0, bus_a.s_ce}, 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_ce_async", {31'b0, bus_a.s_ce}, 32'd0);
        chk("abort_we_async", {31'b0, bus_a.s_we}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus_a.m1_req = 1'b0;
        bus_a.m1_we  = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_no_strobe", we_a_cnt - we0, 0);
        chk("abort_mem_kept", mem_a[192], 32'h5A5A_0300);
        a_m0_read(32'h300, 32'h5A5A_0300, lat);
        chk("abort_idle_latency", lat, WA + 2);

        // ---- dut_b: zero wait states ----
        sb_b.push_back('{mid: MID_INST, rdata: pat_b(32'h44)});
        bus_b.m0_addr = 32'h44;
        bus_b.m0_req = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus_b.m0_ack && lat < 40);
        bus_b.m0_req = 1'b0;
        chk("b_w0_latency", lat, WB + 2);
        @(negedge clk);

        // ---- dut_b: round-robin tie over four transfers ----
        sb_b.push_back('{mid: MID_DATA, rdata: pat_b(32'h88)});
        sb_b.push_back('{mid: MID_INST, rdata: pat_b(32'h44)});
        sb_b.push_back('{mid: MID_DATA, rdata: pat_b(32'h88)});
        sb_b.push_back('{mid: MID_INST, rdata: pat_b(32'h44)});
        bus_b.m1_we = 1'b0; bus_b.m1_addr = 32'h88; bus_b.m1_sel = 4'hF;
        bus_b.m0_addr = 32'h44;
        bus_b.m0_req = 1'b1;
        bus_b.m1_req = 1'b1;
        n0 = 0; n1 = 0; cyc = 0;
        while (n0 < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus_b.m1_ack) begin
                n1++;
                if (n1 == 2) bus_b.m1_req = 1'b0;
            end
            if (bus_b.m0_ack) begin
                n0++;
                if (n0 == 2) bus_b.m0_req = 1'b0;
            end
        end
        bus_b.m0_req = 1'b0;
        bus_b.m1_req = 1'b0;
        chk("tieB_m0_count", n0, 2);
        chk("tieB_m1_count", n1, 2);
        chk("tieB_throughput", cyc, (WB + 2) + 3 * (WB + 3));
        chk("b_no_we", we_b_cnt, 0);

        repeat (4) @(negedge clk);
        chk("sb_a_drained", sb_a.size(), 0);
        chk("sb_b_drained", sb_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_sopc_mem_arbiter
`default_nettype wire
